lc3_control_fsm: RTL and testbench
==================================

Name: lc3_control_fsm

Overview:
Parametrised instruction sequencer/decoder for the LC-3 datapath. It supersedes the week-1 fetch-only sequencer with full fetch/decode/execute for ADD, AND, NOT, LDR, STR, JSR/JSRR, JMP, BR and PAUSE. SRAM wait length and the debug IR pause are configurable. It drives every load, gate, mux and memory strobe of the datapath and sits beside it in the top level.

Parameters:
MEM_WAIT, 1, extra SRAM cycles per access (range 0..7); every read or write strobe is held MEM_WAIT+1 cycles.
PAUSE_EN, 0, 1 inserts PauseIR1/PauseIR2 after fetch (IR inspection via Continue).

Ports:
Clk  in  1  clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
Run, Continue  in  1  start; PAUSE/debug release.
Opcode  in  4  IR[15:12].
IR_5, IR_11, BEN  in  1  IR bits; branch-enable register.
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1  register loads.
GatePC, GateMDR, GateALU, GateMARMUX  out  1  bus gates; exactly one high or none.
PCMUX, ADDR2MUX, ALUK  out  2  mux/ALU selects.
DRMUX, SR1MUX, SR2MUX, ADDR1MUX  out  1  mux selects.
Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1  active-low SRAM controls.
Illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Encodings: PCMUX 00 PC+1, 01 bus, 10 adder; ADDR2MUX 00 zero, 01 off6, 10 off9, 11 off11; ADDR1MUX 0 PC, 1 SR1; DRMUX 0 IR[11:9], 1 R7; SR1MUX 0 IR[11:9], 1 IR[8:6]; ALUK 00 ADD, 01 AND, 10 NOT, 11 PASSA.
- Defaults (every state unless overridden, and during/after reset): all loads, gates and Illegal are 0; selects are 0; Mem_OE=Mem_WE=1. Mem_CE, Mem_UB and Mem_LB are tied to 0.
- Reset low: state goes to Halted immediately; the wait counter clears. Reset mid-access drops the strobes at once.
- Halted: go to S18 when Run=1.
- S18: GatePC, LD_MAR, LD_PC, PCMUX=00.
- S33: Mem_OE=0 for MEM_WAIT+1 cycles; LD_MDR only in the last cycle.
- S35: GateMDR, LD_IR. Next state is PauseIR1 if PAUSE_EN, else S32.
- PauseIR1 waits for Continue=1, then PauseIR2. PauseIR2 waits for Continue=0, then S32.
- S32: LD_BEN, then decode.
  - 0001 goes to S01; 0101 to S05; 1001 to S09; 0110 to S06; 0111 to S07; 0100 to S04; 1100 to S12; 0000 to S00; 1101 to SPause.
  - Any other opcode goes to S18 with Illegal=1 for that cycle.
- S01/S05/S09: SR1MUX=1, SR2MUX=IR_5 (forced 0 in S09), ALUK 00/01/10, GateALU, LD_REG, LD_CC. Next state S18.
- S06/S07: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR. S06 goes to S25, S07 goes to S23.
- S25: read access, same as S33, then S27. S27: GateMDR, LD_REG, LD_CC, then S18.
- S23: SR1MUX=0, ALUK=11, GateALU, LD_MDR, then S16. S16: Mem_WE=0 for MEM_WAIT+1 cycles, then S18. Mem_OE stays 1 throughout.
- S04: GatePC, DRMUX=1, LD_REG. Next state S21 if IR_11=1, else S20.
- S21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC.
- S20 and S12 are identical: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC. Both return to S18.
- S00: next state S22 if BEN=1, else S18. S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC, then S18.
- SPause: LD_LED=1 on the first cycle only. Then wait for Continue=1, then wait for Continue=0, then S18.
- Wait counter: $clog2(MEM_WAIT+2) bits. It loads on entry to S33/S25/S16 and counts down; the state exits when the count is 0. It never wraps.
- Run is ignored outside Halted. Continue is ignored outside the pause states.

Test Plan:
1. MEM_WAIT=1, PAUSE_EN=0, reset then Run pulse, IR=0x1283 (ADD R1,R2,R3) -> S18(1) S33(2) S35(1) S32(1) S01(1) = 6 cycles. Mem_OE low for exactly 2 cycles; in S01 LD_REG=LD_CC=GateALU=1 with SR2MUX=0.
2. MEM_WAIT=2, IR=0x7442 (STR) -> S06 LD_MAR, then S23 LD_MDR ALUK=11, then Mem_WE low for 3 consecutive cycles with Mem_OE=1, then S18.
3. IR=0x0E05 (BRnzp) with BEN=1 -> S22 asserts LD_PC with PCMUX=10, ADDR2MUX=10. Repeat with BEN=0 -> S18 follows S00 directly, no LD_PC.
4. IR=0x4801 (JSR, IR_11=1) -> S04 DRMUX=1 LD_REG, then S21 ADDR2MUX=11. IR=0x4080 (JSRR) -> S20 ADDR1MUX=1.
5. PAUSE_EN=1 and IR=0xD00F -> sequencer holds in PauseIR1 until Continue=1, then PauseIR2 until Continue=0. In SPause, LD_LED pulses exactly once; a 20-cycle Continue hold leaves no further LD_LED. Opcode 1111 -> Illegal=1 for one cycle, then S18.
6. Reset driven low asynchronously mid-S16 (Mem_WE=0) -> Mem_WE=1 and all loads 0 with no clock edge. Reset high -> sequencer stays Halted until Run.

Source files
------------

// File: rtl/lc3_control_fsm.sv
// LC-3 instruction sequencer: fetch/decode/execute control for ADD, AND, NOT,
// LDR, STR, JSR/JSRR, JMP, BR and PAUSE. Drives every datapath load, bus gate,
// mux select and the active-low SRAM strobes. Control outputs are decoded from
// the state register and the wait counter only, except SR2MUX (IR_5) and
// Illegal (Opcode), which must be valid in the same cycle as the state.
module lc3_control_fsm #(
    parameter int unsigned MEM_WAIT = 1,
    parameter bit          PAUSE_EN = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       Illegal
);

    localparam int unsigned     CNT_W    = $clog2(MEM_WAIT + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_WAIT);

    typedef enum logic [4:0] {
        ST_HALTED, ST_S18, ST_S33, ST_S35, ST_PAUSE1, ST_PAUSE2, ST_S32,
        ST_S01, ST_S05, ST_S09, ST_S06, ST_S07, ST_S25, ST_S27, ST_S23,
        ST_S16, ST_S04, ST_S21, ST_S20, ST_S12, ST_S00, ST_S22,
        ST_SPAUSE, ST_SPW1, ST_SPW0
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Opcode decode target; unsupported opcodes fall back to a new fetch.
    function automatic state_t decode_op(input logic [3:0] op);
        case (op)
            4'b0001: decode_op = ST_S01;
            4'b0101: decode_op = ST_S05;
            4'b1001: decode_op = ST_S09;
            4'b0110: decode_op = ST_S06;
            4'b0111: decode_op = ST_S07;
            4'b0100: decode_op = ST_S04;
            4'b1100: decode_op = ST_S12;
            4'b0000: decode_op = ST_S00;
            4'b1101: decode_op = ST_SPAUSE;
            default: decode_op = ST_S18;
        endcase
    endfunction

    // State and wait-counter registers; reset drops straight to Halted.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_HALTED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter loads on entry to a memory access and
    // counts down to zero without wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_HALTED: state_d = Run ? ST_S18 : ST_HALTED;
            ST_S18: begin
                state_d = ST_S33;
                cnt_d   = CNT_LOAD;
            end
            ST_S33: begin
                if (cnt_q == '0) state_d = ST_S35;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_S35:    state_d = PAUSE_EN ? ST_PAUSE1 : ST_S32;
            ST_PAUSE1: state_d = Continue ? ST_PAUSE2 : ST_PAUSE1;
            ST_PAUSE2: state_d = Continue ? ST_PAUSE2 : ST_S32;
            ST_S32:    state_d = decode_op(Opcode);
            ST_S01, ST_S05, ST_S09: state_d = ST_S18;
            ST_S06: begin
                state_d = ST_S25;
                cnt_d   = CNT_LOAD;
            end
            ST_S07:    state_d = ST_S23;
            ST_S25: begin
                if (cnt_q == '0) state_d = ST_S27;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_S27:    state_d = ST_S18;
            ST_S23: begin
                state_d = ST_S16;
                cnt_d   = CNT_LOAD;
            end
            ST_S16: begin
                if (cnt_q == '0) state_d = ST_S18;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_S04:    state_d = IR_11 ? ST_S21 : ST_S20;
            ST_S21, ST_S20, ST_S12, ST_S22: state_d = ST_S18;
            ST_S00:    state_d = BEN ? ST_S22 : ST_S18;
            ST_SPAUSE: state_d = Continue ? ST_SPW0 : ST_SPW1;
            ST_SPW1:   state_d = Continue ? ST_SPW0 : ST_SPW1;
            ST_SPW0:   state_d = Continue ? ST_SPW0 : ST_S18;
            default:   state_d = ST_HALTED;
        endcase
    end

    // Control decode: idle values first, then per-state overrides.
    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
        DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ADDR1MUX = 1'b0;
        Mem_OE = 1'b1; Mem_WE = 1'b1; Illegal = 1'b0;
        case (state_q)
            ST_S18: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = 2'b00;
            end
            ST_S33, ST_S25: begin
                Mem_OE = 1'b0;
                LD_MDR = (cnt_q == '0);
            end
            ST_S35: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
            end
            ST_S32: begin
                LD_BEN  = 1'b1;
                Illegal = (decode_op(Opcode) == ST_S18);
            end
            ST_S01, ST_S05, ST_S09: begin
                SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                if (state_q == ST_S09) begin
                    SR2MUX = 1'b0; ALUK = 2'b10;
                end else if (state_q == ST_S05) begin
                    SR2MUX = IR_5; ALUK = 2'b01;
                end else begin
                    SR2MUX = IR_5; ALUK = 2'b00;
                end
            end
            ST_S06, ST_S07: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
            end
            ST_S27: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            end
            ST_S23: begin
                SR1MUX = 1'b0; ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
            end
            ST_S16: Mem_WE = 1'b0;
            ST_S04: begin
                GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
            end
            ST_S21: begin
                ADDR1MUX = 1'b0; ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1;
            end
            ST_S20, ST_S12: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b00;
                PCMUX = 2'b10; LD_PC = 1'b1;
            end
            ST_S22: begin
                ADDR1MUX = 1'b0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1;
            end
            ST_SPAUSE: LD_LED = 1'b1;
            default: begin
                // Halted, pause waits and S00 keep the idle values.
            end
        endcase
    end

    // Chip enable and byte lanes are permanently active.
    assign Mem_CE = 1'b0;
    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed table-driven bench for lc3_control_fsm. Two instances share the
// inputs: g_dut[0] uses MEM_WAIT=1/PAUSE_EN=0, g_dut[1] uses MEM_WAIT=2/PAUSE_EN=1.
// Each table row is one clock cycle: inputs plus the expected output label.
module tb_lc3_control_fsm;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we, illegal;
    } ctl_t;

    typedef enum {
        L_IDLE, L_S18, L_RD, L_RDL, L_S35, L_S32, L_ILL, L_ADD, L_AND, L_NOT,
        L_EA, L_S27, L_S23, L_WR, L_S04, L_S21, L_S20, L_S22, L_LED
    } label_t;

    typedef struct {
        logic       rst;
        logic       sel;
        logic       run;
        logic       cont;
        logic [3:0] op;
        logic       ir5;
        logic       ir11;
        logic       ben;
        label_t     lab;
    } row_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;

    ctl_t       act [2];
    logic [2:0] tie [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic drmux, sr1mux, sr2mux, addr1mux;
        logic mem_ce, mem_ub, mem_lb, mem_oe, mem_we, illegal;

        lc3_control_fsm #(
            .MEM_WAIT((g == 0) ? 1 : 2),
            .PAUSE_EN((g == 1) ? 1'b1 : 1'b0)
        ) u_dut (
            .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
            .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
            .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
            .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
            .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu),
            .GateMARMUX(gate_marmux), .PCMUX(pcmux), .ADDR2MUX(addr2mux),
            .ALUK(aluk), .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux),
            .ADDR1MUX(addr1mux), .Mem_CE(mem_ce), .Mem_UB(mem_ub),
            .Mem_LB(mem_lb), .Mem_OE(mem_oe), .Mem_WE(mem_we), .Illegal(illegal)
        );

        assign act[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                         gate_pc, gate_mdr, gate_alu, gate_marmux,
                         pcmux, addr2mux, aluk,
                         drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we, illegal};
        assign tie[g] = {mem_ce, mem_ub, mem_lb};
    end

    always #5 Clk = ~Clk;

    int   n_vec = 0;
    int   n_err = 0;
    row_t tbl[$];

    logic       cur_sel;
    logic [3:0] cur_op;
    logic       cur_ir5, cur_ir11, cur_ben;

    // Expected control word for each labelled cycle, written from the encodings.
    function automatic ctl_t ctl_for(input label_t l, input logic ir5);
        ctl_t e;
        e = '0;
        e.mem_oe = 1'b1;
        e.mem_we = 1'b1;
        case (l)
            L_S18: begin e.gate_pc = 1'b1; e.ld_mar = 1'b1; e.ld_pc = 1'b1; end
            L_RD:  e.mem_oe = 1'b0;
            L_RDL: begin e.mem_oe = 1'b0; e.ld_mdr = 1'b1; end
            L_S35: begin e.gate_mdr = 1'b1; e.ld_ir = 1'b1; end
            L_S32: e.ld_ben = 1'b1;
            L_ILL: begin e.ld_ben = 1'b1; e.illegal = 1'b1; end
            L_ADD, L_AND, L_NOT: begin
                e.sr1mux = 1'b1; e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
                e.sr2mux = (l == L_NOT) ? 1'b0 : ir5;
                e.aluk   = (l == L_ADD) ? 2'b00 : (l == L_AND) ? 2'b01 : 2'b10;
            end
            L_EA: begin
                e.sr1mux = 1'b1; e.addr1mux = 1'b1; e.addr2mux = 2'b01;
                e.gate_marmux = 1'b1; e.ld_mar = 1'b1;
            end
            L_S27: begin e.gate_mdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1; end
            L_S23: begin e.aluk = 2'b11; e.gate_alu = 1'b1; e.ld_mdr = 1'b1; end
            L_WR:  e.mem_we = 1'b0;
            L_S04: begin e.gate_pc = 1'b1; e.drmux = 1'b1; e.ld_reg = 1'b1; end
            L_S21: begin e.addr2mux = 2'b11; e.pcmux = 2'b10; e.ld_pc = 1'b1; end
            L_S20: begin
                e.sr1mux = 1'b1; e.addr1mux = 1'b1; e.pcmux = 2'b10; e.ld_pc = 1'b1;
            end
            L_S22: begin e.addr2mux = 2'b10; e.pcmux = 2'b10; e.ld_pc = 1'b1; end
            L_LED: e.ld_led = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string nm, input logic sel, input label_t l, input logic ir5);
        ctl_t e;
        e = ctl_for(l, ir5);
        n_vec++;
        if ({act[sel], tie[sel]} !== {e, 3'b000}) begin
            n_err++;
            $display("FAIL %s dut%0d %s: got %h/%b want %h/000",
                     nm, sel, l.name(), act[sel], tie[sel], e);
        end
    endtask

    task automatic set_insn(input logic sel, input logic [3:0] op,
                            input logic ir5, input logic ir11, input logic ben);
        cur_sel = sel; cur_op = op; cur_ir5 = ir5; cur_ir11 = ir11; cur_ben = ben;
    endtask

    task automatic rowf(input logic rst, input label_t l, input logic run, input logic cont);
        row_t r;
        r.rst = rst; r.sel = cur_sel; r.run = run; r.cont = cont; r.op = cur_op;
        r.ir5 = cur_ir5; r.ir11 = cur_ir11; r.ben = cur_ben; r.lab = l;
        tbl.push_back(r);
    endtask

    task automatic row(input label_t l, input logic cont);
        rowf(1'b0, l, 1'b0, cont);
    endtask

    // S18, MEM_WAIT+1 read cycles (last loads MDR), S35.
    task automatic fetch(input int mw);
        row(L_S18, 1'b0);
        for (int k = 0; k < mw; k++) row(L_RD, 1'b0);
        row(L_RDL, 1'b0);
        row(L_S35, 1'b0);
    endtask

    task automatic apply_row(input row_t v, input int idx);
        if (v.rst) begin
            Reset = 1'b0;
            #1;
            Reset = 1'b1;
        end
        Run = v.run; Continue = v.cont; Opcode = v.op;
        IR_5 = v.ir5; IR_11 = v.ir11; BEN = v.ben;
        #1;
        check($sformatf("row%0d", idx), v.sel, v.lab, v.ir5);
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'h0;
        IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;

        // ---- instance 0: MEM_WAIT=1, no IR pause ----
        set_insn(1'b0, 4'h1, 1'b0, 1'b0, 1'b0);            // ADD R1,R2,R3
        rowf(1'b0, L_IDLE, 1'b1, 1'b0);
        fetch(1); row(L_S32, 1'b0); row(L_ADD, 1'b0);
        set_insn(1'b0, 4'h5, 1'b1, 1'b0, 1'b0);            // AND immediate
        fetch(1); row(L_S32, 1'b0); row(L_AND, 1'b0);
        set_insn(1'b0, 4'h9, 1'b1, 1'b0, 1'b0);            // NOT, IR_5 ignored
        fetch(1); row(L_S32, 1'b0); row(L_NOT, 1'b0);
        set_insn(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);            // BRnzp taken
        fetch(1); row(L_S32, 1'b0); row(L_IDLE, 1'b0); row(L_S22, 1'b0);
        set_insn(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);            // BR not taken
        fetch(1); row(L_S32, 1'b0); row(L_IDLE, 1'b0);
        set_insn(1'b0, 4'h4, 1'b0, 1'b1, 1'b0);            // JSR
        fetch(1); row(L_S32, 1'b0); row(L_S04, 1'b0); row(L_S21, 1'b0);
        set_insn(1'b0, 4'h4, 1'b0, 1'b0, 1'b0);            // JSRR
        fetch(1); row(L_S32, 1'b0); row(L_S04, 1'b0); row(L_S20, 1'b0);
        set_insn(1'b0, 4'h6, 1'b0, 1'b0, 1'b0);            // LDR
        fetch(1); row(L_S32, 1'b0); row(L_EA, 1'b0);
        row(L_RD, 1'b0); row(L_RDL, 1'b0); row(L_S27, 1'b0);
        set_insn(1'b0, 4'hC, 1'b0, 1'b0, 1'b0);            // JMP
        fetch(1); row(L_S32, 1'b0); row(L_S20, 1'b0);
        set_insn(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);            // unsupported
        fetch(1); row(L_ILL, 1'b0);
        set_insn(1'b0, 4'h2, 1'b0, 1'b0, 1'b0);            // LD is unsupported too
        fetch(1); row(L_ILL, 1'b0);
        set_insn(1'b0, 4'h1, 1'b1, 1'b0, 1'b0);            // ADD immediate
        fetch(1); row(L_S32, 1'b0); row(L_ADD, 1'b0); row(L_S18, 1'b0);

        // ---- instance 1: MEM_WAIT=2, IR pause enabled ----
        set_insn(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);            // STR
        rowf(1'b1, L_IDLE, 1'b1, 1'b0);
        fetch(2);
        row(L_IDLE, 1'b0); row(L_IDLE, 1'b0); row(L_IDLE, 1'b0);  // PauseIR1 holds
        row(L_IDLE, 1'b1); row(L_IDLE, 1'b1); row(L_IDLE, 1'b1);  // PauseIR2 holds
        row(L_IDLE, 1'b0);
        row(L_S32, 1'b0); row(L_EA, 1'b0); row(L_S23, 1'b0);
        row(L_WR, 1'b0); row(L_WR, 1'b0); row(L_WR, 1'b0);
        set_insn(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);            // PAUSE
        fetch(2);
        row(L_IDLE, 1'b1); row(L_IDLE, 1'b0);
        row(L_S32, 1'b0); row(L_LED, 1'b0);
        row(L_IDLE, 1'b0); row(L_IDLE, 1'b0);
        for (int k = 0; k < 20; k++) row(L_IDLE, 1'b1);
        row(L_IDLE, 1'b0);
        row(L_S18, 1'b0);

        #2;
        check("reset0", 1'b0, L_IDLE, 1'b0);
        check("reset1", 1'b1, L_IDLE, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);

        // ---- asynchronous reset in the middle of a write ----
        tbl.delete();
        set_insn(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        rowf(1'b1, L_IDLE, 1'b1, 1'b0);
        fetch(2);
        row(L_IDLE, 1'b1); row(L_IDLE, 1'b0);
        row(L_S32, 1'b0); row(L_EA, 1'b0); row(L_S23, 1'b0); row(L_WR, 1'b0);
        for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], 100 + i);
        #1;
        check("mid_write", 1'b1, L_WR, 1'b0);
        #1;
        Reset = 1'b0;
        #1;
        check("async_rst", 1'b1, L_IDLE, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        tbl.delete();
        row(L_IDLE, 1'b0); row(L_IDLE, 1'b1); row(L_IDLE, 1'b0);
        rowf(1'b0, L_IDLE, 1'b1, 1'b0);
        row(L_S18, 1'b0); row(L_RD, 1'b0);
        for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], 200 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
